// File: rtl/bcd_display_mux.sv
// bcd_display_mux: latches four BCD digits plus decimal points and drives a
// 4-digit common-anode multiplexed 7-segment display. A refresh prescaler sets
// how many clocks each digit stays lit. The BCD-to-segment decode supports
// optional leading-zero blanking. All display outputs come straight from flops.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        scan_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; 10..15 show a dash.
  function automatic logic [6:0] decode_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       dpl_q, dpl_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  logic [3:0]       zero_s;
  logic [3:0]       blank_s;
  logic [3:0]       digit_s;

  // Refresh prescaler and scan index: advance to the next digit when the prescaler wraps.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Digit and decimal-point latch: capture on load, otherwise hold.
  always_comb begin
    bcd_d = bcd_q;
    dpl_d = dpl_q;
    if (load) begin
      bcd_d = bcd_in;
      dpl_d = dp_in;
    end else begin
      bcd_d = bcd_q;
      dpl_d = dpl_q;
    end
  end

  // Leading-zero map: a digit is blankable when it and every higher digit are zero.
  always_comb begin
    zero_s[0]  = (bcd_q[3:0]   == 4'd0);
    zero_s[1]  = (bcd_q[7:4]   == 4'd0);
    zero_s[2]  = (bcd_q[11:8]  == 4'd0);
    zero_s[3]  = (bcd_q[15:12] == 4'd0);
    blank_s[3] = zero_s[3];
    blank_s[2] = zero_s[3] & zero_s[2];
    blank_s[1] = zero_s[3] & zero_s[2] & zero_s[1];
    blank_s[0] = 1'b0;
  end

  // Next display state for the currently selected digit; the tick marks an anode change.
  always_comb begin
    digit_s = bcd_q[{idx_q, 2'b00} +: 4];
    an_d    = ~(4'b0001 << idx_q);
    dp_d    = ~dpl_q[idx_q];
    if (blank_lz && blank_s[idx_q]) begin
      seg_d = SEG_OFF;
    end else begin
      seg_d = decode_seg(digit_s);
    end
    tick_d = (an_d != an_q);
  end

  // State and output registers; reset blanks the display and restarts the scan at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      bcd_q  <= 16'd0;
      dpl_q  <= 4'd0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      bcd_q  <= bcd_d;
      dpl_q  <= dpl_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench for bcd_display_mux with REFRESH_DIV=4. The stimulus process
// pushes the hand-computed display state expected at each scan_tick; a monitor
// pops and compares on every tick, including the clock spacing between ticks.
module tb_bcd_display_mux;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        scan_tick;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] SDSH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;

  bcd_display_mux #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input int g);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // One 16-clock frame: expect digits 0..3, then load the next frame's data
  // so the latch changes on the last edge of this frame.
  task automatic frame(input logic blz, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpe,
                       input int g0, input logic [15:0] nb, input logic [3:0] nd);
    blank_lz = blz;
    push(4'b1110, s0, dpe[0], g0);
    push(4'b1101, s1, dpe[1], 4);
    push(4'b1011, s2, dpe[2], 4);
    push(4'b0111, s3, dpe[3], 4);
    repeat (15) @(negedge clk);
    bcd_in = nb;
    dp_in  = nd;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Monitor: compares each tick against the scoreboard and checks anode changes only occur on ticks.
  initial begin
    int         cyc;
    logic [3:0] prev_an;
    exp_t       e;
    cyc     = 0;
    prev_an = 4'hF;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        cyc     = 0;
        prev_an = 4'hF;
      end else begin
        cyc++;
        if (an !== prev_an) chk("an_moves_with_tick", {31'd0, scan_tick}, 32'd1);
        if (scan_tick === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: got tick with an=%b, required no tick", an);
          end else begin
            e = exp_q.pop_front();
            chk("tick_an",  {28'd0, an},  {28'd0, e.an});
            chk("tick_seg", {25'd0, seg}, {25'd0, e.seg});
            chk("tick_dp",  {31'd0, dp},  {31'd0, e.dp});
            chk("tick_gap", cyc, e.gap);
          end
          cyc = 0;
        end
        prev_an = an;
      end
    end
  end

  // Stimulus: directed frames with hand-computed expectations.
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an",   {28'd0, an},        32'hF);
    chk("rst_seg",  {25'd0, seg},       32'h7F);
    chk("rst_dp",   {31'd0, dp},        32'd1);
    chk("rst_tick", {31'd0, scan_tick}, 32'd0);
    #2 rst = 1'b0;

    // Cleared latch, no blanking: all digits show 0.
    frame(1'b0, S0, S0, S0, S0, 4'b1111, 1, 16'h1234, 4'b0100);
    // 1234 with decimal point on digit 2.
    frame(1'b0, S4, S3, S2, S1, 4'b1011, 4, 16'h0070, 4'b0000);
    // 0070 with blanking: digits 3,2 dark.
    frame(1'b1, S0, S7, SOFF, SOFF, 4'b1111, 4, 16'h0000, 4'b0000);
    // 0000 with blanking: only digit 0 lit.
    frame(1'b1, S0, SOFF, SOFF, SOFF, 4'b1111, 4, 16'hA00F, 4'b0000);
    // A00F: dashes on 3 and 0, zeros in between are not leading.
    frame(1'b1, SDSH, S0, S0, SDSH, 4'b1111, 4, 16'hA00F, 4'b0000);

    // Mid-scan load of 5555 while index=2.
    blank_lz = 1'b1;
    push(4'b1110, SDSH, 1'b1, 4);
    push(4'b1101, S0,   1'b1, 4);
    push(4'b1011, S0,   1'b1, 4);
    push(4'b0111, S5,   1'b0, 4);
    repeat (9) @(negedge clk);
    chk("midload_before_seg", {25'd0, seg}, {25'd0, S0});
    bcd_in = 16'h5555;
    dp_in  = 4'b1000;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    chk("midload_same_edge_seg", {25'd0, seg}, {25'd0, S0});
    @(negedge clk);
    chk("midload_next_seg", {25'd0, seg}, {25'd0, S5});
    chk("midload_next_an",  {28'd0, an},  32'hB);
    chk("midload_next_dp",  {31'd0, dp},  32'd1);
    repeat (5) @(negedge clk);

    // Async reset while digit 2 is lit.
    push(4'b1110, S5, 1'b1, 4);
    push(4'b1101, S5, 1'b1, 4);
    push(4'b1011, S5, 1'b1, 4);
    repeat (10) @(negedge clk);
    chk("prereset_an", {28'd0, an}, 32'hB);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_an",   {28'd0, an},        32'hF);
    chk("async_rst_seg",  {25'd0, seg},       32'h7F);
    chk("async_rst_dp",   {31'd0, dp},        32'd1);
    chk("async_rst_tick", {31'd0, scan_tick}, 32'd0);
    #1 rst = 1'b0;

    // Restart from digit 0 with a cleared latch (blanking still on).
    frame(1'b1, S0, SOFF, SOFF, SOFF, 4'b1111, 1, 16'h0000, 4'b0000);

    rst = 1'b1;
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
